// File: rtl/adc_cap_pkg.sv
// ============================================================================
// Module   : adc_cap_pkg
// Purpose  : Shared types and constants for the ADC capture sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_cap_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        CAPTURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } cap_state_t;

    localparam int c_DATA_W_DFLT = 12;
    // FIFO entry is {last, sample}; the last flag sits in the MSB.
    localparam int c_ENTRY_W     = c_DATA_W_DFLT + 1;
    localparam int c_OVF_CNT_W   = 16;

    function automatic int fifo_entry_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_cap_fifo.sv
// ============================================================================
// Module   : adc_cap_fifo
// Purpose  : Synchronous FIFO with flop-based storage, full/empty flags and
//            a flush input. Output reads zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_cap_fifo
    import adc_cap_pkg::*;
#(
    parameter int WIDTH = c_ENTRY_W,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = c_AW + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_wr;
    logic               w_do_rd;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_do_rd   = i_rd_en && !o_empty;
    // A read in the same cycle frees the slot, so a write into a full FIFO succeeds.
    assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr && !i_flush && !rst) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
// ============================================================================
// Module   : adc_capture_ctrl
// Purpose  : AD9235 capture sequencer: enables the sample clock, discards the
//            pipeline-latency strobes, captures a fixed number of samples
//            into a FIFO and streams them out. Define ADC_CAP_OVF_CNT_EN to
//            add the o_ovf_cnt dropped-sample counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_capture_ctrl
    import adc_cap_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int DATA_W     = 12,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int PIPE_DLY   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_div_cfg,
    input  logic [LEN_W-1:0]  i_num_samples,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_adc_en,
    output logic [CNT_W-1:0]  o_adc_div,
    input  logic              i_adc_fall,
    input  logic [DATA_W-1:0] i_adc_data,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic              o_m_last,
    output logic              o_overflow
`ifdef ADC_CAP_OVF_CNT_EN
    ,
    output logic [c_OVF_CNT_W-1:0] o_ovf_cnt
`endif
);

    localparam int c_FIFO_W = fifo_entry_w(DATA_W);
    localparam int c_DLY_W  = (PIPE_DLY > 1) ? $clog2(PIPE_DLY) : 1;

    cap_state_t          r_state;
    cap_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_adc_div;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_smp_cnt;
    logic [c_DLY_W-1:0]  r_fall_cnt;
    logic                r_adc_en;
    logic                r_overflow;

    logic                w_accept;
    logic                w_fall_inc;
    logic                w_wr_en;
    logic                w_drop;
    logic                w_can_write;
    logic                w_is_last;
    logic                w_flush_last;
    logic [LEN_W-1:0]    w_smp_nxt;
    logic [c_FIFO_W-1:0] w_rd_data;
    logic                w_fifo_empty;
    logic                w_fifo_full;

    assign w_smp_nxt    = r_smp_cnt + LEN_W'(1);
    assign w_is_last    = (w_smp_nxt == r_len);
    assign w_flush_last = (r_fall_cnt == c_DLY_W'(PIPE_DLY - 1));
    assign w_can_write  = !w_fifo_full || i_m_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fall_inc  = 1'b0;
        w_wr_en     = 1'b0;
        w_drop      = 1'b0;
        if (i_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && (i_num_samples != '0)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    if (PIPE_DLY == 0) begin
                        w_state_nxt = CAPTURE;
                    end else if (i_adc_fall) begin
                        w_fall_inc = 1'b1;
                        if (w_flush_last) w_state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (i_adc_fall) begin
                        if (w_can_write) begin
                            w_wr_en = 1'b1;
                            if (w_is_last) w_state_nxt = DRAIN;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (o_m_valid && i_m_ready && o_m_last) w_state_nxt = DONE;
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Abort clears the counters but keeps the divider and the sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_adc_div  <= '0;
            r_len      <= '0;
            r_smp_cnt  <= '0;
            r_fall_cnt <= '0;
            r_adc_en   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (i_abort) begin
            r_adc_en   <= 1'b0;
            r_smp_cnt  <= '0;
            r_fall_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_adc_div  <= i_div_cfg;
                r_len      <= i_num_samples;
                r_smp_cnt  <= '0;
                r_fall_cnt <= '0;
                r_adc_en   <= 1'b1;
                r_overflow <= 1'b0;
            end
            if (w_fall_inc) r_fall_cnt <= r_fall_cnt + c_DLY_W'(1);
            if (w_wr_en) begin
                r_smp_cnt <= w_smp_nxt;
                if (w_is_last) r_adc_en <= 1'b0;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

`ifdef ADC_CAP_OVF_CNT_EN
    logic [c_OVF_CNT_W-1:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (!i_abort) begin
            if (w_accept)                       r_ovf_cnt <= '0;
            else if (w_drop && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + c_OVF_CNT_W'(1);
        end
    end

    assign o_ovf_cnt = r_ovf_cnt;
`endif

    adc_cap_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (i_abort),
        .i_wr_en   (w_wr_en),
        .i_wr_data ({w_is_last, i_adc_data}),
        .i_rd_en   (i_m_ready),
        .o_rd_data (w_rd_data),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full)
    );

    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);
    assign o_adc_en   = r_adc_en;
    assign o_adc_div  = r_adc_div;
    assign o_overflow = r_overflow;
    assign o_m_valid  = !w_fifo_empty;
    assign o_m_data   = w_rd_data[DATA_W-1:0];
    assign o_m_last   = w_rd_data[c_FIFO_W-1];

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
// ============================================================================
// Module   : tb_adc_capture_ctrl
// Purpose  : Randomized self-checking bench for adc_capture_ctrl against a
//            queue-based reference model; instance A uses PIPE_DLY=7,
//            instance B uses PIPE_DLY=0.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adc_capture_ctrl;

    localparam int c_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, fall = 1'b0, ready = 1'b0, sel_b = 1'b0;
    logic [11:0] div_cfg = '0, adc_data = '0;
    logic [15:0] num = '0;

    logic        busy_a, done_a, en_a, val_a, last_a, ovf_a;
    logic        busy_b, done_b, en_b, val_b, last_b, ovf_b;
    logic [11:0] div_a, dat_a, div_b, dat_b;
`ifdef ADC_CAP_OVF_CNT_EN
    logic [15:0] ovfc_a, ovfc_b, ovfc;
    assign ovfc = sel_b ? ovfc_b : ovfc_a;
`endif

    logic        busy, done, en, mval, mlast, ovf;
    logic [11:0] adiv, mdat;
    assign busy  = sel_b ? busy_b : busy_a;
    assign done  = sel_b ? done_b : done_a;
    assign en    = sel_b ? en_b   : en_a;
    assign mval  = sel_b ? val_b  : val_a;
    assign mlast = sel_b ? last_b : last_a;
    assign ovf   = sel_b ? ovf_b  : ovf_a;
    assign adiv  = sel_b ? div_b  : div_a;
    assign mdat  = sel_b ? dat_b  : dat_a;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_capture_ctrl #(.PIPE_DLY(7)) u_dut_a (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .i_div_cfg(div_cfg), .i_num_samples(num),
        .o_busy(busy_a), .o_done(done_a), .o_adc_en(en_a), .o_adc_div(div_a),
        .i_adc_fall(fall), .i_adc_data(adc_data),
        .o_m_data(dat_a), .o_m_valid(val_a), .i_m_ready(ready), .o_m_last(last_a),
        .o_overflow(ovf_a)
`ifdef ADC_CAP_OVF_CNT_EN
        , .o_ovf_cnt(ovfc_a)
`endif
    );

    adc_capture_ctrl #(.PIPE_DLY(0)) u_dut_b (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .i_div_cfg(div_cfg), .i_num_samples(num),
        .o_busy(busy_b), .o_done(done_b), .o_adc_en(en_b), .o_adc_div(div_b),
        .i_adc_fall(fall), .i_adc_data(adc_data),
        .o_m_data(dat_b), .o_m_valid(val_b), .i_m_ready(ready), .o_m_last(last_b),
        .o_overflow(ovf_b)
`ifdef ADC_CAP_OVF_CNT_EN
        , .o_ovf_cnt(ovfc_b)
`endif
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; abort = 1'b0; fall = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One capture transaction. The model: the first dly strobes after the
    // start are discarded; each later strobe is stored if the queue (after
    // this cycle's pop) has room, otherwise dropped; a beat is offered while
    // the queue is non-empty; done follows the beat carrying last.
    // rmode: 0 ready=1, 1 random, 2 low until 18 post-flush strobes, 3 low.
    // smode: 0 strobe every 8 cycles with data 0x100+index, 1 random.
    task automatic run_capture(input string tag, input int dly, input logic [11:0] dv,
                               input int n, input int rmode, input int smode,
                               input int abort_at, input bit rst_drain, input bit stray,
                               output int beats, output int drops,
                               output int first_d, output int last_d);
        logic [12:0] q[$];
        logic [12:0] e;
        logic [11:0] exp_div;
        int          seen, acc, sidx;
        bit          exp_en, exp_done, exp_busy, hs, popped_last, fin, ended, was_rst;
        beats = 0; drops = 0; first_d = -1; last_d = -1;
        seen = 0; acc = 0; sidx = 0; was_rst = 0;

        @(posedge clk); #1;
        start = 1'b1; div_cfg = dv; num = n[15:0]; fall = 1'b0; abort = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; div_cfg = 12'($urandom); num = 16'($urandom);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || en !== 1'b1 || adiv !== dv) begin
            bad++;
            $display("FAIL %s start_resp busy=%0b en=%0b div=%0h want busy=1 en=1 div=%0h",
                     tag, busy, en, adiv, dv);
        end
        exp_en = 1; exp_done = 0; exp_busy = 1; exp_div = dv; fin = 0; ended = 0;

        for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
            @(posedge clk); #1;
            abort = 1'b0; rst = 1'b0; start = 1'b0; fall = 1'b0;
            if (!fin) begin
                if (abort_at >= 0 && beats == abort_at && acc < n) abort = 1'b1;
                if (rst_drain && acc == n && q.size() == n) rst = 1'b1;
                if (acc < n) begin
                    fall = (smode == 0) ? (cyc % 8 == 7) : ($urandom_range(0, 2) == 0);
                    if (stray && $urandom_range(0, 9) == 0) begin
                        start = 1'b1; div_cfg = 12'd9; num = 16'd5;
                    end
                end
            end
            adc_data = (smode == 0) ? 12'(32'h100 + sidx) : 12'($urandom);
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                2:       ready = (acc + drops >= 18);
                default: ready = 1'b0;
            endcase

            @(negedge clk);
            total++;
            if (mval !== (q.size() > 0)) begin
                bad++;
                $display("FAIL %s m_valid got=%0b want=%0b", tag, mval, q.size() > 0);
            end
            if (q.size() > 0) begin
                total++;
                if ({mlast, mdat} !== q[0]) begin
                    bad++;
                    $display("FAIL %s beat got last=%0b data=%0h want last=%0b data=%0h",
                             tag, mlast, mdat, q[0][12], q[0][11:0]);
                end
            end
            total++;
            if (en !== exp_en) begin
                bad++; $display("FAIL %s adc_en got=%0b want=%0b", tag, en, exp_en);
            end
            total++;
            if (done !== exp_done) begin
                bad++; $display("FAIL %s done got=%0b want=%0b", tag, done, exp_done);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++; $display("FAIL %s busy got=%0b want=%0b", tag, busy, exp_busy);
            end
            total++;
            if (adiv !== exp_div) begin
                bad++; $display("FAIL %s adc_div got=%0h want=%0h", tag, adiv, exp_div);
            end

            if (fin) begin
                if (was_rst) begin
                    total++;
                    if (ovf !== 1'b0 || mdat !== 12'h0 || mlast !== 1'b0) begin
                        bad++;
                        $display("FAIL %s rst_vals ovf=%0b data=%0h last=%0b want 0 0 0",
                                 tag, ovf, mdat, mlast);
                    end
                end
                ended = 1;
            end else if (exp_done) begin
                fin = 1; exp_done = 0; exp_busy = 0;
            end else if (rst) begin
                q.delete(); exp_en = 0; exp_busy = 0; exp_div = '0; fin = 1; was_rst = 1;
            end else if (abort) begin
                q.delete(); exp_en = 0; exp_busy = 0; fin = 1;
            end else begin
                hs = (q.size() > 0) && ready;
                popped_last = 0;
                if (hs) begin
                    e = q.pop_front();
                    popped_last = e[12];
                    if (beats == 0) first_d = int'(e[11:0]);
                    last_d = int'(e[11:0]);
                    beats++;
                end
                if (fall) begin
                    if (seen < dly) begin
                        seen++;
                    end else if (acc < n) begin
                        if (q.size() < c_DEPTH) begin
                            acc++;
                            q.push_back({acc == n, adc_data});
                            if (acc == n) exp_en = 0;
                        end else begin
                            drops++;
                        end
                    end
                    sidx++;
                end
                exp_done = popped_last;
            end
        end

        rst = 1'b0; abort = 1'b0; fall = 1'b0; start = 1'b0;
        if (!ended) begin
            total++; bad++;
            $display("FAIL %s timeout got=running want=finished", tag);
        end else if (!was_rst) begin
            total++;
            if (ovf !== (drops > 0)) begin
                bad++; $display("FAIL %s overflow got=%0b want=%0b", tag, ovf, drops > 0);
            end
`ifdef ADC_CAP_OVF_CNT_EN
            total++;
            if (ovfc !== 16'(drops)) begin
                bad++; $display("FAIL %s ovf_cnt got=%0d want=%0d", tag, ovfc, drops);
            end
`endif
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({busy_a, done_a, en_a, div_a, val_a, last_a, ovf_a, dat_a} !== '0 ||
            {busy_b, done_b, en_b, div_b, val_b, last_b, ovf_b, dat_b} !== '0) begin
            bad++;
            $display("FAIL reset_vals got a=%0b%0b%0b %0h %0b%0b%0b %0h want all zero",
                     busy_a, done_a, en_a, div_a, val_a, last_a, ovf_a, dat_a);
        end
    endtask

    task automatic test_nominal();
        int b, d, f, l;
        sel_b = 1'b0;
        do_reset();
        run_capture("nominal", 7, 12'd3, 4, 0, 0, -1, 0, 0, b, d, f, l);
        total++;
        if (b != 4 || f != 'h107 || l != 'h10A || d != 0) begin
            bad++;
            $display("FAIL nominal_seq got beats=%0d first=%0h last=%0h drops=%0d want 4 107 10a 0",
                     b, f, l, d);
        end
    endtask

    task automatic test_overflow();
        int b, d, f, l;
        sel_b = 1'b0;
        do_reset();
        run_capture("overflow", 7, 12'd5, 20, 2, 1, -1, 0, 0, b, d, f, l);
        total++;
        if (b != 20 || d != 2) begin
            bad++;
            $display("FAIL overflow_cnt got beats=%0d drops=%0d want beats=20 drops=2", b, d);
        end
    endtask

    task automatic test_abort();
        int b, d, f, l, n;
        sel_b = 1'b0;
        do_reset();
        run_capture("abort", 7, 12'd7, 10, 0, 0, 2, 0, 0, b, d, f, l);
        total++;
        if (b != 2) begin
            bad++; $display("FAIL abort_beats got=%0d want=2", b);
        end
        n = $urandom_range(1, 20);
        run_capture("after_abort", 7, 12'd11, n, 1, 1, -1, 0, 0, b, d, f, l);
        total++;
        if (b != n) begin
            bad++; $display("FAIL after_abort_beats got=%0d want=%0d", b, n);
        end
    endtask

    task automatic test_ignored_start();
        int b, d, f, l;
        sel_b = 1'b0;
        do_reset();
        @(posedge clk); #1;
        start = 1'b1; num = 16'd0; div_cfg = 12'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || en !== 1'b0) begin
                bad++;
                $display("FAIL zero_len got busy=%0b done=%0b en=%0b want 0 0 0", busy, done, en);
            end
        end
        run_capture("stray_start", 7, 12'h5A5, 8, 1, 1, -1, 0, 1, b, d, f, l);
        total++;
        if (b != 8) begin
            bad++; $display("FAIL stray_beats got=%0d want=8", b);
        end
    endtask

    task automatic test_edge();
        int b, d, f, l;
        sel_b = 1'b1;
        do_reset();
        run_capture("edge", 0, 12'd0, 1, 0, 0, -1, 0, 0, b, d, f, l);
        total++;
        if (b != 1 || f != 'h100) begin
            bad++; $display("FAIL edge_seq got beats=%0d first=%0h want 1 100", b, f);
        end
    endtask

    task automatic test_random();
        int b, d, f, l, n;
        for (int k = 0; k < 6; k++) begin
            sel_b = k[0];
            do_reset();
            n = $urandom_range(1, 40);
            run_capture("random", sel_b ? 0 : 7, 12'($urandom), n, 1, 1, -1, 0, 0, b, d, f, l);
            total++;
            if (b != n) begin
                bad++; $display("FAIL random_beats got=%0d want=%0d", b, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b, d, f, l;
        sel_b = 1'b0;
        do_reset();
        run_capture("reset_mid", 7, 12'd6, 3, 3, 1, -1, 1, 0, b, d, f, l);
        total++;
        if (b != 0) begin
            bad++; $display("FAIL reset_mid_beats got=%0d want=0", b);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overflow();
        test_abort();
        test_ignored_start();
        test_edge();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture sequencer for the AD9235 ADC clock/strobe generator. On a start command it loads the divider setting and enables the sample clock. It discards the converter's pipeline-latency samples, then captures exactly `num_samples` words on the falling-edge strobe into a small FIFO and streams them out with a valid/ready handshake. It sits between the ADC clock generator and the downstream DMA/stream logic, and owns that generator's `en` and `cnt_reg` inputs.

## Interface
- `CNT_W`, 12, divider width; matches the clock generator's `cnt_reg`.
- `DATA_W`, 12, ADC sample width.
- `LEN_W`, 16, width of the sample-count request.
- `FIFO_DEPTH`, 16, output FIFO entries; power of two, ≥2.
- `PIPE_DLY`, 7, strobes discarded after enable (ADC pipeline latency); 0 allowed.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: capture request, sampled in IDLE only.
- `abort` in 1: cancel any operation.
- `div_cfg` in CNT_W: divider value latched at start.
- `num_samples` in LEN_W: samples to deliver; 0 = request ignored.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at completion.
- `adc_en` out 1: drives the clock generator `en`.
- `adc_div` out CNT_W: drives the clock generator `cnt_reg`.
- `adc_fall` in 1: sample strobe, the `en_Fall` output of the clock generator.
- `adc_data` in DATA_W: ADC output bus, valid when `adc_fall` is high.
- `m_data` out DATA_W, `m_valid` out 1, `m_ready` in 1, `m_last` out 1: output stream.
- `overflow` out 1: sticky flag; a sample arrived while the FIFO was full.

## Operation
- States: IDLE, FLUSH, CAPTURE, DRAIN, DONE.
- IDLE, with `start=1` and `num_samples!=0`:
  - Latch `div_cfg` into `adc_div` and `num_samples` into the length register.
  - Clear `overflow`, the strobe counter and the sample counter.
  - Set `adc_en=1` and go to FLUSH.
- IDLE, with `num_samples=0`: `start` is ignored and no `done` is produced.
- `start` outside IDLE is ignored.
- `adc_div` changes only on a latch and holds during busy.
- FLUSH:
  - Count `adc_fall` pulses; discarded samples are never written.
  - After the PIPE_DLY-th pulse, go to CAPTURE.
  - With `PIPE_DLY=0`, go FLUSH→CAPTURE on the cycle after entry.
- CAPTURE, on each `adc_fall`:
  - FIFO not full: write `{last, adc_data}` and increment the sample counter. `last=1` when the counter reaches the latched length.
  - FIFO full: drop the sample, set `overflow`, and do not advance the counter. The block always delivers exactly `num_samples` beats.
  - After the last write: `adc_en←0` and go to DRAIN.
- A simultaneous FIFO read and write while full is allowed; the write succeeds.
- DRAIN: wait for the handshake (`m_valid & m_ready`) on the beat with `m_last=1`, then go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- `abort`, in any state:
  - Next cycle: IDLE, `adc_en=0`, FIFO emptied, counters cleared.
  - No `done`. `overflow` and `adc_div` are held.
- `abort` has priority over `start` and over `adc_fall` in the same cycle.
- `m_data`/`m_last` hold stable while `m_valid & !m_ready`.

## Timing
- Reset values: `busy`, `done`, `adc_en`, `adc_div`, `m_valid`, `m_last`, `overflow` all 0; `m_data` 0; FIFO empty; state IDLE.
- `start` at cycle t → `busy=1` and `adc_en=1` at t+1.
- `adc_fall` write at cycle t → `m_valid=1` at t+1 (registered FIFO, 1-cycle latency).
- `overflow` rises at t+1 after the dropped strobe.
- Last accepted strobe at t → `adc_en=0` at t+1.
- Final `m_last` handshake at t → `done=1` at t+1 → `busy=0` at t+2.
- Reset asserted mid-capture: all outputs take their reset values on the next edge; the in-flight sample is lost.

## Configuration
- `ADC_CAP_OVF_CNT_EN` defined:
  - Adds output `ovf_cnt` (out, 16 bits): count of dropped samples, saturating at 0xFFFF.
  - Cleared on an accepted start and on reset; held on abort.
- Undefined: the port and counter are absent; only the sticky `overflow` flag exists.

## Structure
- Package `adc_cap_pkg`: state enum (IDLE/FLUSH/CAPTURE/DRAIN/DONE), FIFO entry width constant (`DATA_W+1`, last bit in the MSB), overflow counter width constant (16).
- One sub-module, `adc_cap_fifo`:
  - Synchronous FIFO with registered output, full/empty flags and a flush input.
  - Width `DATA_W+1`, depth `FIFO_DEPTH`.

## Test plan
1. **Nominal capture:** `div_cfg=3`, `num_samples=4`, `PIPE_DLY=7`, `m_ready=1`, strobe every 8 cycles with data 0x100+i → beats 0x107..0x10A; `m_last` on 0x10A; `adc_en` low the cycle after the 11th strobe; `done` one cycle after the last beat; `overflow=0`.
2. **Overflow:** `num_samples=20`, `m_ready=0` for 18 strobes after flush, then `m_ready=1` → 16 stored, 2 dropped; `overflow=1`; `ovf_cnt=2` with the macro; 20 beats total, `m_last` on the 20th.
3. **Abort:** abort in CAPTURE after 2 beats → next cycle `adc_en=0`, `busy=0`, `m_valid=0`, no `done`; a new start then captures normally.
4. **Ignored starts:** `start` with `num_samples=0` → `busy` stays 0; `start` pulsed during CAPTURE with `div_cfg=9` → `adc_div` keeps its original value.
5. **Edge parameters:** `PIPE_DLY=0`, `div_cfg=0`, `num_samples=1` → first strobe captured; single beat with `m_last=1`; `done` follows.
6. **Reset mid-operation:** `rst` in DRAIN with 3 entries queued → all outputs at reset values next cycle; FIFO empty.
